// File: rtl/pps_pkg.sv
// Shared PPS definitions: FSM state encoding, default timing constants and
// a saturating byte increment used by the event counters.
package pps_pkg;

    // Defaults for a 100 MHz reference clock
    localparam int unsigned PPS_NOMINAL_DEF  = 100_000_000;
    localparam int unsigned PPS_TOL_DEF      = 1_000;
    localparam int unsigned PPS_LOCK_CNT_DEF = 3;
    localparam int unsigned PPS_CNT_W_DEF    = 28;

    // Qualifier FSM encoding, kept as plain constants for legacy compatibility
    typedef logic [1:0] pps_state_t;
    localparam pps_state_t ST_HUNT = 2'd0;
    localparam pps_state_t ST_ACQ  = 2'd1;
    localparam pps_state_t ST_LOCK = 2'd2;

    // Increment that sticks at 255 instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pps_monitor_if.sv
// PPS monitor signal bundle: raw PPS and clear in, qualified results out.
// The master side drives i_pps/i_clr; the slave side is the monitor itself.
interface pps_monitor_if
    import pps_pkg::*;
#(
    parameter int unsigned P_CNT_W = PPS_CNT_W_DEF
) ();

    logic               i_pps;
    logic               i_clr;
    logic               o_pps_q;
    logic [P_CNT_W-1:0] o_period;
    logic               o_period_en;
    logic               o_valid;
    logic [7:0]         o_miss_cnt;
    logic [7:0]         o_err_cnt;

    modport master (
        output i_pps, i_clr,
        input  o_pps_q, o_period, o_period_en, o_valid, o_miss_cnt, o_err_cnt
    );

    modport slave (
        input  i_pps, i_clr,
        output o_pps_q, o_period, o_period_en, o_valid, o_miss_cnt, o_err_cnt
    );

endinterface

// File: rtl/pps_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detect for a raw PPS.
// An edge is only reported after a genuine post-reset low has been seen, so a
// line that is already high when reset releases never yields a false edge.
module pps_sync_edge (
    input  logic clk,
    input  logic res_n,
    input  logic din,
    output logic rise
);

    logic s1, s2, prev;
    logic fill1, fill2, armed;

    // Metastability filter
    always_ff @(posedge clk) begin
        if (!res_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // fill2 marks s2 as holding a real post-reset sample; arm on the first real low
    always_ff @(posedge clk) begin
        if (!res_n) begin
            fill1 <= 1'b0;
            fill2 <= 1'b0;
            armed <= 1'b0;
        end else begin
            fill1 <= 1'b1;
            fill2 <= fill1;
            if (fill2 && !s2) begin
                armed <= 1'b1;
            end
        end
    end

    // One-cycle registered rising-edge event
    always_ff @(posedge clk) begin
        if (!res_n) begin
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            prev <= s2;
            rise <= s2 && !prev && armed;
        end
    end

endmodule

// File: rtl/pps_monitor.sv
// PPS qualifier: measures each PPS period against the reference clock,
// classifies edges as good/early/missing, and declares lock after a run of
// good periods. Drives qualified strobe, last period, counters and lock flag.
module pps_monitor
    import pps_pkg::*;
#(
    parameter int unsigned P_NOMINAL  = PPS_NOMINAL_DEF,
    parameter int unsigned P_TOL      = PPS_TOL_DEF,
    parameter int unsigned P_LOCK_CNT = PPS_LOCK_CNT_DEF,
    parameter int unsigned P_CNT_W    = PPS_CNT_W_DEF
) (
    input  logic         i_clk,
    input  logic         i_res_n,
    pps_monitor_if.slave mon
);

    localparam logic [P_CNT_W-1:0] GOOD_MIN = P_CNT_W'(P_NOMINAL - P_TOL);
    localparam logic [P_CNT_W-1:0] TERM_CNT = P_CNT_W'(P_NOMINAL + P_TOL + 1);
    localparam logic [3:0]         LOCK_RUN = 4'(P_LOCK_CNT);

    pps_state_t         state, state_n;
    logic [P_CNT_W-1:0] cnt, cnt_n;
    logic [3:0]         run, run_n;
    logic               pps_edge;
    logic               timeout;
    logic               good_edge;
    logic               early_edge;

    pps_sync_edge u_sync (
        .clk   (i_clk),
        .res_n (i_res_n),
        .din   (mon.i_pps),
        .rise  (pps_edge)
    );

    // Next state: timeout is resolved first, then a coincident edge is treated
    // as a fresh HUNT edge so the same cycle re-acquires.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        run_n      = run;
        timeout    = 1'b0;
        good_edge  = 1'b0;
        early_edge = 1'b0;
        if (state != ST_HUNT) begin
            cnt_n = cnt + P_CNT_W'(1);
            if (cnt == TERM_CNT) begin
                timeout = 1'b1;
                state_n = ST_HUNT;
                run_n   = '0;
                cnt_n   = '0;
            end
        end
        if (pps_edge) begin
            cnt_n = P_CNT_W'(1);
            if (state_n == ST_HUNT) begin
                state_n = ST_ACQ;
                run_n   = '0;
            end else if (cnt >= GOOD_MIN) begin
                good_edge = 1'b1;
                run_n     = (run >= LOCK_RUN) ? LOCK_RUN : run + 4'd1;
                if (run_n == LOCK_RUN) begin
                    state_n = ST_LOCK;
                end
            end else begin
                early_edge = 1'b1;
                run_n      = '0;
                state_n    = ST_ACQ;
            end
        end
    end

    // FSM, period counter and good-run register
    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            state <= ST_HUNT;
            cnt   <= '0;
            run   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            run   <= run_n;
        end
    end

    // Qualified outputs, registered alongside the state change
    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            mon.o_pps_q     <= 1'b0;
            mon.o_period    <= '0;
            mon.o_period_en <= 1'b0;
            mon.o_valid     <= 1'b0;
        end else begin
            mon.o_period_en <= good_edge;
            mon.o_pps_q     <= good_edge && (state_n == ST_LOCK);
            mon.o_valid     <= (state_n == ST_LOCK);
            if (good_edge) begin
                mon.o_period <= cnt;
            end
        end
    end

    // Miss counter; clear overrides a coincident increment
    always_ff @(posedge i_clk) begin
        if (!i_res_n || mon.i_clr) begin
            mon.o_miss_cnt <= '0;
        end else if (timeout) begin
            mon.o_miss_cnt <= sat_inc8(mon.o_miss_cnt);
        end
    end

    // Early-edge counter; clear overrides a coincident increment
    always_ff @(posedge i_clk) begin
        if (!i_res_n || mon.i_clr) begin
            mon.o_err_cnt <= '0;
        end else if (early_edge) begin
            mon.o_err_cnt <= sat_inc8(mon.o_err_cnt);
        end
    end

endmodule

// File: tb/tb_pps_monitor.sv
// Self-checking bench for pps_monitor: edge-sequence table, reset corner
// cases, randomized periods against a timestamp-based reference model, and a
// short-period instance for counter saturation and clear priority.
module tb_pps_monitor;
    import pps_pkg::*;

    localparam int unsigned NOM   = 1000;
    localparam int unsigned TOL   = 10;
    localparam int unsigned LCK   = 3;
    localparam int unsigned CW    = 12;
    localparam int unsigned S_NOM = 20;
    localparam int unsigned S_TOL = 2;
    localparam int unsigned S_CW  = 6;

    logic clk = 1'b0;
    logic res_n = 1'b0;
    always #5 clk = ~clk;

    pps_monitor_if #(.P_CNT_W(CW))   bus  ();
    pps_monitor_if #(.P_CNT_W(S_CW)) sbus ();

    pps_monitor #(.P_NOMINAL(NOM), .P_TOL(TOL), .P_LOCK_CNT(LCK), .P_CNT_W(CW)) dut (
        .i_clk(clk), .i_res_n(res_n), .mon(bus.slave)
    );
    pps_monitor #(.P_NOMINAL(S_NOM), .P_TOL(S_TOL), .P_LOCK_CNT(LCK), .P_CNT_W(S_CW)) dut_s (
        .i_clk(clk), .i_res_n(res_n), .mon(sbus.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model (timestamp based) ----------------
    bit          sb_en = 1'b0;
    int unsigned cyc = 0;
    int unsigned since_rst = 0;
    bit          smp[$];
    bit          ev;
    bit          m_track, m_lock;
    int unsigned m_ref, m_run, m_miss, m_err, m_per;
    bit          e_q, e_en;

    always @(posedge clk) begin
        cyc++;
        smp.push_back(bus.i_pps);
        if (smp.size() > 5) void'(smp.pop_front());
        e_q  = 1'b0;
        e_en = 1'b0;
        if (!res_n) begin
            since_rst = 0;
            m_track = 0; m_lock = 0; m_ref = 0; m_run = 0;
            m_miss = 0; m_err = 0; m_per = 0;
        end else begin
            // rising edge of the raw input, seen 3 samples later, post-reset history only
            ev = (since_rst >= 4) && (smp.size() == 5) && smp[1] && !smp[0];
            if (m_track && (cyc - m_ref == NOM + TOL + 1)) begin
                if (m_miss < 255) m_miss++;
                m_track = 0; m_lock = 0; m_run = 0;
            end
            if (ev) begin
                if (!m_track) begin
                    m_track = 1; m_lock = 0; m_run = 0;
                end else if (cyc - m_ref >= NOM - TOL) begin
                    m_per = cyc - m_ref;
                    e_en  = 1;
                    m_run = (m_run < LCK) ? m_run + 1 : LCK;
                    if (m_run == LCK) m_lock = 1;
                    e_q = m_lock;
                end else begin
                    if (m_err < 255) m_err++;
                    m_run = 0; m_lock = 0;
                end
                m_ref = cyc;
            end
            if (bus.i_clr) begin
                m_miss = 0;
                m_err  = 0;
            end
            since_rst++;
        end
    end

    always @(negedge clk) begin
        if (sb_en) begin
            checks++;
            if ({bus.o_pps_q, bus.o_period_en, bus.o_period, bus.o_valid, bus.o_miss_cnt, bus.o_err_cnt} !==
                {e_q, e_en, CW'(m_per), m_lock, 8'(m_miss), 8'(m_err)}) begin
                errors++;
                $display("FAIL model cyc=%0d got q=%b en=%b per=%0d val=%b miss=%0d err=%0d expected q=%b en=%b per=%0d val=%b miss=%0d err=%0d",
                         cyc, bus.o_pps_q, bus.o_period_en, bus.o_period, bus.o_valid, bus.o_miss_cnt, bus.o_err_cnt,
                         e_q, e_en, m_per, m_lock, m_miss, m_err);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    typedef struct {
        logic [CW-1:0] per;
        logic          en, val, q;
        logic [7:0]    miss, err;
    } snap_t;

    // One PPS period: rising edge sampled at the first cycle, high for 'hi' cycles.
    // Outputs are captured 3 cycles after the rising sample, when that edge resolves.
    task automatic pps_cycle(input int unsigned gap, input int unsigned hi, input bit clr_rand, output snap_t s);
        s = '{default: '0};
        for (int unsigned i = 0; i < gap; i++) begin
            bus.i_pps = (i < hi);
            bus.i_clr = clr_rand && ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
            if (i == 3) begin
                s.per = bus.o_period; s.en = bus.o_period_en; s.val = bus.o_valid;
                s.q = bus.o_pps_q; s.miss = bus.o_miss_cnt; s.err = bus.o_err_cnt;
            end
        end
        bus.i_clr = 1'b0;
    endtask

    // Short-period instance: edges every S_NOM+S_TOL+1 cycles, optional clear on the edge cycle
    task automatic spulse(input bit with_clr);
        for (int unsigned i = 0; i < S_NOM + S_TOL + 1; i++) begin
            sbus.i_pps = (i < 3);
            sbus.i_clr = with_clr && (i == 3);
            @(posedge clk); #1;
        end
        sbus.i_clr = 1'b0;
    endtask

    typedef struct {
        int unsigned gap;
        bit          en;
        int unsigned per;
        bit          val;
        bit          q;
        int unsigned err;
        int unsigned miss;
    } vec_t;

    vec_t  tbl[18];
    snap_t s;

    initial begin
        // gap = cycles to the next edge; expectations are for the edge that starts this row
        tbl[0]  = '{1000, 1'b0,    0, 1'b0, 1'b0, 0, 0};  // HUNT -> ACQ
        tbl[1]  = '{1000, 1'b1, 1000, 1'b0, 1'b0, 0, 0};
        tbl[2]  = '{1000, 1'b1, 1000, 1'b0, 1'b0, 0, 0};
        tbl[3]  = '{1000, 1'b1, 1000, 1'b1, 1'b1, 0, 0};  // 4th edge locks
        tbl[4]  = '{ 985, 1'b1, 1000, 1'b1, 1'b1, 0, 0};
        tbl[5]  = '{1000, 1'b0, 1000, 1'b0, 1'b0, 1, 0};  // 985 early
        tbl[6]  = '{1000, 1'b1, 1000, 1'b0, 1'b0, 1, 0};
        tbl[7]  = '{1000, 1'b1, 1000, 1'b0, 1'b0, 1, 0};
        tbl[8]  = '{ 990, 1'b1, 1000, 1'b1, 1'b1, 1, 0};  // relock
        tbl[9]  = '{1010, 1'b1,  990, 1'b1, 1'b1, 1, 0};  // 990 good
        tbl[10] = '{ 989, 1'b1, 1010, 1'b1, 1'b1, 1, 0};  // 1010 good
        tbl[11] = '{1011, 1'b0, 1010, 1'b0, 1'b0, 2, 0};  // 989 early
        tbl[12] = '{1000, 1'b0, 1010, 1'b0, 1'b0, 2, 1};  // 1011: miss, re-acquire
        tbl[13] = '{1000, 1'b1, 1000, 1'b0, 1'b0, 2, 1};
        tbl[14] = '{1000, 1'b1, 1000, 1'b0, 1'b0, 2, 1};
        tbl[15] = '{1500, 1'b1, 1000, 1'b1, 1'b1, 2, 1};  // lock, then timeout in LOCK
        tbl[16] = '{1000, 1'b0, 1000, 1'b0, 1'b0, 2, 2};  // HUNT edge, no period
        tbl[17] = '{1000, 1'b1, 1000, 1'b0, 1'b0, 2, 2};

        bus.i_pps = 1'b0;  bus.i_clr = 1'b0;
        sbus.i_pps = 1'b0; sbus.i_clr = 1'b0;
        res_n = 1'b0;
        @(posedge clk); #1;
        sb_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_pps_q", bus.o_pps_q, 0);
        chk("rst_period", bus.o_period, 0);
        chk("rst_miss", bus.o_miss_cnt, 0);
        res_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // table-driven edge sequence
        for (int i = 0; i < 18; i++) begin
            pps_cycle(tbl[i].gap, 5, 1'b0, s);
            chk($sformatf("tbl%0d_en", i),   s.en,   tbl[i].en);
            chk($sformatf("tbl%0d_per", i),  s.per,  tbl[i].per);
            chk($sformatf("tbl%0d_val", i),  s.val,  tbl[i].val);
            chk($sformatf("tbl%0d_q", i),    s.q,    tbl[i].q);
            chk($sformatf("tbl%0d_err", i),  s.err,  tbl[i].err);
            chk($sformatf("tbl%0d_miss", i), s.miss, tbl[i].miss);
        end

        // relock, then reset mid-period with i_pps high across release
        pps_cycle(1000, 5, 1'b0, s);
        pps_cycle(1000, 5, 1'b0, s);
        chk("relock_val", s.val, 1);
        pps_cycle(400, 5, 1'b0, s);
        bus.i_pps = 1'b1;
        res_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid", bus.o_valid, 0);
        chk("midrst_period", bus.o_period, 0);
        chk("midrst_en", bus.o_period_en, 0);
        chk("midrst_q", bus.o_pps_q, 0);
        chk("midrst_miss", bus.o_miss_cnt, 0);
        chk("midrst_err", bus.o_err_cnt, 0);
        res_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        bus.i_pps = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        pps_cycle(1000, 5, 1'b0, s);
        chk("post_rst_first_en", s.en, 0);
        chk("post_rst_first_err", s.err, 0);
        pps_cycle(1000, 5, 1'b0, s);
        chk("post_rst_second_en", s.en, 1);
        chk("post_rst_second_per", s.per, 1000);
        chk("post_rst_second_err", s.err, 0);

        // randomized periods around the tolerance window, random clears
        for (int k = 0; k < 25; k++) begin
            int unsigned gap;
            case ($urandom_range(0, 9))
                0:       gap = $urandom_range(400, 988);
                1:       gap = $urandom_range(1012, 1300);
                2:       gap = 989;
                3:       gap = 1011;
                default: gap = $urandom_range(990, 1010);
            endcase
            pps_cycle(gap, $urandom_range(1, 50), 1'b1, s);
        end

        // saturation and clear priority on the short-period instance
        for (int k = 0; k < 301; k++) spulse(1'b0);
        chk("sat_miss", sbus.o_miss_cnt, 255);
        chk("sat_err", sbus.o_err_cnt, 0);
        chk("sat_valid", sbus.o_valid, 0);
        spulse(1'b1);
        chk("clr_vs_miss_sat", sbus.o_miss_cnt, 0);
        spulse(1'b0);
        chk("miss_after_clr", sbus.o_miss_cnt, 1);
        spulse(1'b1);
        chk("clr_vs_miss", sbus.o_miss_cnt, 0);

        sb_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pps_monitor.md
# pps_monitor

Qualifies a raw 1PPS input against the 100 MHz reference-derived clock before it feeds phase measurement, the PPS generator sync path, and UART reporting. Measures every PPS period and classifies each edge as good, early or missing, and declares lock after a run of good periods. Outputs a qualified PPS strobe, last-period value, miss/error counters and a lock flag for the reporting and LED logic.

## Interface
- P_NOMINAL, 100_000_000: nominal period in i_clk cycles.
- P_TOL, 1_000: accepted deviation in cycles, ±, inclusive.
- P_LOCK_CNT, 3: consecutive good periods needed to enter LOCK (1..15).
- P_CNT_W, 28: period counter width; must hold P_NOMINAL+P_TOL+1.
- i_clk, input, 1: 100 MHz reference clock; only clock.
- i_res_n, input, 1: synchronous active-low reset.
- i_pps, input, 1: raw asynchronous PPS, rising edge is on-time.
- i_clr, input, 1: one-cycle pulse that clears o_miss_cnt and o_err_cnt.
- o_pps_q, output, 1: one-cycle qualified PPS strobe.
- o_period, output, P_CNT_W: last measured period, in cycles.
- o_period_en, output, 1: one-cycle strobe when o_period updates.
- o_valid, output, 1: high while in LOCK.
- o_miss_cnt, output, 8: saturating count of timeouts.
- o_err_cnt, output, 8: saturating count of early edges.

## Operation
- i_pps goes through a 2-FF synchronizer, then a rising-edge detector. The result is an "edge" event, one cycle per rising edge.
- Period = cycles between consecutive edge events (edges at cycles t0 and t1 give t1−t0).
- The period counter runs in ACQ and LOCK, restarts on each edge event, and is held at 0 in HUNT.
- States:
  - HUNT: reset state, no reference edge. An edge moves to ACQ and clears the good-run count.
  - ACQ: reference edge held, good-run count < P_LOCK_CNT.
  - LOCK: o_valid=1.
- Edge classification in ACQ and LOCK:
  - Good: P_NOMINAL−P_TOL ≤ period ≤ P_NOMINAL+P_TOL.
    - Update o_period and pulse o_period_en.
    - Increment good-run count, saturating at P_LOCK_CNT.
    - In ACQ, reaching P_LOCK_CNT moves to LOCK.
  - Early: period < P_NOMINAL−P_TOL.
    - Increment o_err_cnt (saturates at 255).
    - Clear good-run count and go to ACQ. That edge becomes the new reference.
    - o_period is not updated.
- Timeout: in ACQ or LOCK, the counter reaches P_NOMINAL+P_TOL+1 with no edge.
  - Increment o_miss_cnt (saturates at 255).
  - Clear good-run count and go to HUNT.
- o_pps_q pulses on every good edge that leaves the FSM in LOCK, including the edge that enters LOCK. It never pulses in HUNT or ACQ.
- Width rules:
  - Period compare is unsigned, P_CNT_W bits.
  - The counter never wraps because timeout fires first.
  - Counters saturate and do not wrap.

## Timing
- o_pps_q and o_period_en assert exactly 3 i_clk cycles after the first cycle i_pps is sampled high (2 sync + 1 edge detect).
- o_valid changes in the same cycle as the state register, 3 cycles after the triggering edge. On timeout it drops the cycle after the terminal count.
- Reset: all outputs 0, state HUNT, counters 0, synchronizer flops 0. Reset mid-period discards the measurement. A high i_pps at release produces no edge until it goes low and then high again.
- Timeout and an edge event in the same cycle: timeout wins (miss counted, HUNT). The edge is then taken as a HUNT edge in that same cycle, so the next state is ACQ.
- i_clr in the same cycle as an increment: clear wins, counter = 0.
- Pulses shorter than one i_clk cycle may be missed. This is accepted.

## Structure
- Package pps_pkg: state encoding (HUNT/ACQ/LOCK) and default constants for P_NOMINAL, P_TOL and P_LOCK_CNT, shared with freq_counter and pps_gen.
- Sub-module pps_sync_edge: 2-FF synchronizer plus rising-edge detect. It is reusable for PPS2–PPS4.
- Top body: FSM, period counter, classifier, saturating counters.

## Test plan
All benches use P_NOMINAL=1000, P_TOL=10, P_LOCK_CNT=3.
- Edges every 1000 cycles → o_period=1000 with o_period_en per edge. o_valid rises 3 cycles after the 4th edge, with o_pps_q on that edge and every later one.
- In LOCK, an edge at period 985 → o_err_cnt=1 and state ACQ (o_valid=0, no o_pps_q). Three further 1000-cycle periods relock.
- In LOCK, no edge for 1011 cycles → o_miss_cnt=1, o_valid=0, HUNT. The next edge gives no o_period_en; the one after gives o_period_en.
- Boundary periods 990 and 1010 are good; 989 is early; an edge at 1011 coincides with timeout → miss counted, next state ACQ.
- 300 consecutive timeouts → o_miss_cnt saturates at 255. i_clr in the same cycle as a miss → 0.
- Reset asserted mid-period while in LOCK → all outputs 0 next cycle. With i_pps held high across release, no edge until i_pps goes low and then high again.
